// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter into one memory controller; one request held per port,
// transactions the controller never completes are aborted after TIMEOUT wait cycles.
module mem_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  a_cmd,
  input  logic [24:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic        a_ready,
  output logic        a_busy,
  output logic        a_valid,
  output logic        a_err,
  output logic [15:0] a_rdata,
  input  logic [1:0]  b_cmd,
  input  logic [24:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic        b_ready,
  output logic        b_busy,
  output logic        b_valid,
  output logic        b_err,
  output logic [15:0] b_rdata,
  output logic [1:0]  mc_cmd,
  output logic [24:0] mc_addr,
  output logic [15:0] mc_wdata,
  output logic        mc_ready,
  input  logic        mc_valid,
  input  logic [15:0] mc_rdata
);
  localparam logic [1:0]  CMD_WR = 2'b10;
  localparam logic [1:0]  CMD_RD = 2'b01;
  localparam logic [10:0] TO_LIM = 11'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]  in_cmd   [2];
  logic [24:0] in_addr  [2];
  logic [15:0] in_wdata [2];
  logic [1:0]  in_rdy;
  logic [1:0]  q_cmd    [2];
  logic [24:0] q_addr   [2];
  logic [15:0] q_wdata  [2];
  logic [15:0] rdata    [2];
  logic [1:0]  pend, tail, busy, vld, err;
  logic        gnt, last_gnt, to_err, wait_last;
  logic [9:0]  cnt;

  assign in_cmd[0]   = a_cmd;
  assign in_cmd[1]   = b_cmd;
  assign in_addr[0]  = a_addr;
  assign in_addr[1]  = b_addr;
  assign in_wdata[0] = a_wdata;
  assign in_wdata[1] = b_wdata;
  assign in_rdy      = {b_ready, a_ready};

  // tail keeps a port busy through its completion pulse so a new request cannot race it
  assign busy      = pend | tail;
  assign wait_last = (({1'b0, cnt} + 11'd1) == TO_LIM);

  assign a_busy  = busy[0];
  assign b_busy  = busy[1];
  assign a_valid = vld[0];
  assign b_valid = vld[1];
  assign a_err   = err[0];
  assign b_err   = err[1];
  assign a_rdata = rdata[0];
  assign b_rdata = rdata[1];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mc_cmd    = 2'b00;
    mc_addr   = '0;
    mc_wdata  = '0;
    mc_ready  = 1'b0;
    case (state)
      IDLE: if (|pend) state_nxt = ISSUE;
      ISSUE: begin
        mc_cmd    = q_cmd[gnt];
        mc_addr   = q_addr[gnt];
        mc_wdata  = q_wdata[gnt];
        mc_ready  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        mc_cmd   = q_cmd[gnt];
        mc_addr  = q_addr[gnt];
        mc_wdata = q_wdata[gnt];
        if (mc_valid || wait_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend     <= '0;
      tail     <= '0;
      vld      <= '0;
      err      <= '0;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      to_err   <= 1'b0;
      cnt      <= '0;
      for (int p = 0; p < 2; p++) begin
        q_cmd[p]   <= '0;
        q_addr[p]  <= '0;
        q_wdata[p] <= '0;
        rdata[p]   <= '0;
      end
    end else begin
      vld  <= '0;
      err  <= '0;
      tail <= '0;
      for (int p = 0; p < 2; p++) begin
        if (in_rdy[p] && !busy[p]) begin
          if (in_cmd[p] == CMD_WR || in_cmd[p] == CMD_RD) begin
            pend[p]    <= 1'b1;
            q_cmd[p]   <= in_cmd[p];
            q_addr[p]  <= in_addr[p];
            q_wdata[p] <= in_wdata[p];
          end else begin
            err[p] <= 1'b1;
          end
        end
      end
      case (state)
        // on a tie, the port not served last wins
        IDLE: if (|pend) gnt <= (&pend) ? ~last_gnt : pend[1];
        ISSUE: begin
          cnt    <= '0;
          to_err <= 1'b0;
        end
        WAIT: begin
          if (mc_valid) begin
            if (q_cmd[gnt] == CMD_RD) rdata[gnt] <= mc_rdata;
          end else if (wait_last) begin
            to_err <= 1'b1;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        DONE: begin
          pend[gnt] <= 1'b0;
          tail[gnt] <= 1'b1;
          last_gnt  <= gnt;
          if (to_err) err[gnt] <= 1'b1;
          else        vld[gnt] <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0, rst = 1'b0;
  logic [1:0]  a_cmd = '0, b_cmd = '0;
  logic [24:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic        a_ready = 1'b0, b_ready = 1'b0;
  logic        a_busy, a_valid, a_err, b_busy, b_valid, b_err;
  logic [15:0] a_rdata, b_rdata;
  logic [1:0]  mc_cmd;
  logic [24:0] mc_addr;
  logic [15:0] mc_wdata;
  logic        mc_ready;
  logic        mc_valid = 1'b0;
  logic [15:0] mc_rdata = '0;

  int n_tests = 0, n_fail = 0;

  always #10 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .a_cmd(a_cmd), .a_addr(a_addr), .a_wdata(a_wdata), .a_ready(a_ready),
    .a_busy(a_busy), .a_valid(a_valid), .a_err(a_err), .a_rdata(a_rdata),
    .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata), .b_ready(b_ready),
    .b_busy(b_busy), .b_valid(b_valid), .b_err(b_err), .b_rdata(b_rdata),
    .mc_cmd(mc_cmd), .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
    .mc_valid(mc_valid), .mc_rdata(mc_rdata)
  );

  // Model: each port holds at most one job; a granted job spends one issue cycle, then
  // waits until mc_valid or TO cycles, then one closing cycle, then reports.
  bit          m_pend[2], m_hold[2], m_vld[2], m_err[2];
  logic [1:0]  m_cmd[2];
  logic [24:0] m_addr[2];
  logic [15:0] m_wd[2], m_rdata[2];
  int          m_job = -1, m_step = 0, m_waited = 0, m_last = 1;
  bit          m_timed_out = 1'b0;

  logic [1:0]  i_cmd[2];
  logic [24:0] i_addr[2];
  logic [15:0] i_wd[2];
  bit          i_rdy[2], busy_now[2];

  always @(posedge clk) begin
    i_cmd[0] = a_cmd;   i_cmd[1] = b_cmd;
    i_addr[0] = a_addr; i_addr[1] = b_addr;
    i_wd[0] = a_wdata;  i_wd[1] = b_wdata;
    i_rdy[0] = a_ready; i_rdy[1] = b_ready;
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        m_pend[p] = 0; m_hold[p] = 0; m_vld[p] = 0; m_err[p] = 0; m_rdata[p] = '0;
      end
      m_job = -1;
      m_last = 1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        busy_now[p] = m_pend[p] | m_hold[p];
        m_vld[p] = 0; m_err[p] = 0; m_hold[p] = 0;
      end
      if (m_job >= 0) begin
        if (m_step == 1) begin
          m_step = 2; m_waited = 0;
        end else if (m_step == 2) begin
          m_waited++;
          if (mc_valid) begin
            if (m_cmd[m_job] == 2'b01) m_rdata[m_job] = mc_rdata;
            m_timed_out = 0; m_step = 3;
          end else if (m_waited == TO) begin
            m_timed_out = 1; m_step = 3;
          end
        end else begin
          if (m_timed_out) m_err[m_job] = 1; else m_vld[m_job] = 1;
          m_pend[m_job] = 0; m_hold[m_job] = 1; m_last = m_job; m_job = -1;
        end
      end else if (m_pend[0] || m_pend[1]) begin
        m_job  = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[0] ? 0 : 1);
        m_step = 1;
      end
      for (int p = 0; p < 2; p++) begin
        if (i_rdy[p] && !busy_now[p]) begin
          if (i_cmd[p] == 2'b10 || i_cmd[p] == 2'b01) begin
            m_pend[p] = 1; m_cmd[p] = i_cmd[p]; m_addr[p] = i_addr[p]; m_wd[p] = i_wd[p];
          end else begin
            m_err[p] = 1;
          end
        end
      end
    end
  end

  task automatic check_cycle();
    logic [81:0] act, exp;
    logic [1:0]  e_cmd;
    logic [24:0] e_addr;
    logic [15:0] e_wd;
    logic        e_rdy;
    e_cmd = '0; e_addr = '0; e_wd = '0; e_rdy = 1'b0;
    if (m_job >= 0 && (m_step == 1 || m_step == 2)) begin
      e_cmd = m_cmd[m_job]; e_addr = m_addr[m_job]; e_wd = m_wd[m_job]; e_rdy = (m_step == 1);
    end
    act = {a_busy, b_busy, a_valid, b_valid, a_err, b_err, mc_ready, mc_cmd, mc_addr,
           mc_wdata, a_rdata, b_rdata};
    exp = {m_pend[0] | m_hold[0], m_pend[1] | m_hold[1], m_vld[0], m_vld[1], m_err[0],
           m_err[1], e_rdy, e_cmd, e_addr, e_wd, m_rdata[0], m_rdata[1]};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle@%0t got %h expected %h (busy,vld,err,mc_ready,cmd,addr,wdata,rdata)",
               $time, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, na, nb, ni;
    int order[8];

    // reset state
    @(posedge clk);
    tick();
    chk("reset busy", 32'({a_busy, b_busy, a_valid, b_valid, a_err, b_err}), 0);
    chk("reset mc", 32'({mc_ready, mc_cmd}), 0);
    chk("reset rdata", 32'({a_rdata, b_rdata}), 0);
    rst = 1'b1;

    // A write, controller answers 5 cycles after issue
    a_ready = 1; a_cmd = 2'b10; a_addr = 25'h0FFFF; a_wdata = 16'hAAAA;
    tick(); chk("wr busy", 32'({a_busy, b_busy, mc_ready}), 32'b100);
    a_ready = 0;
    tick(); chk("wr issue", 32'({mc_ready, mc_cmd}), 32'b110);
    chk("wr addr", 32'(mc_addr), 32'h0FFFF);
    chk("wr wdata", 32'(mc_wdata), 32'hAAAA);
    for (int i = 0; i < 5; i++) tick();
    chk("wr held", 32'({mc_ready, mc_addr}), 32'h0FFFF);
    mc_valid = 1; mc_rdata = 16'h7777;
    tick(); mc_valid = 0;
    chk("wr done no pulse", 32'(a_valid), 0);
    tick(); chk("wr valid", 32'({a_valid, a_err, a_busy, b_busy, b_valid}), 32'b10100);
    tick(); chk("wr after", 32'({a_valid, a_busy}), 0);
    chk("wr no rdata", 32'(a_rdata), 0);

    // illegal command on B
    b_ready = 1; b_cmd = 2'b11;
    tick(); chk("ill err", 32'({b_err, b_busy, mc_ready}), 32'b100);
    b_ready = 0;
    tick(); chk("ill after", 32'({b_err, b_busy, mc_ready}), 0);
    tick(); chk("ill no issue", 32'(mc_ready), 0);

    // simultaneous requests right after reset
    rst = 0; tick(); rst = 1;
    a_ready = 1; a_cmd = 2'b01; a_addr = 25'h10;
    b_ready = 1; b_cmd = 2'b10; b_addr = 25'h20; b_wdata = 16'h1234;
    tick(); chk("tie busy", 32'({a_busy, b_busy}), 32'b11);
    a_ready = 0; b_ready = 0;
    tick(); chk("tie A first", 32'({mc_ready, mc_cmd, mc_addr}), {4'd0, 1'b1, 2'b01, 25'h10});
    tick(); mc_valid = 1; mc_rdata = 16'h5A3C;
    tick(); mc_valid = 0; mc_rdata = 16'h0;
    tick(); chk("tie A valid", 32'({a_valid, b_valid}), 32'b10);
    chk("tie A rdata", 32'(a_rdata), 32'h5A3C);
    tick(); chk("tie B issue", 32'({mc_ready, mc_cmd, mc_addr}), {4'd0, 1'b1, 2'b10, 25'h20});
    chk("tie B wdata", 32'(mc_wdata), 32'h1234);
    tick(); mc_valid = 1;
    tick(); mc_valid = 0;
    tick(); chk("tie B valid", 32'({a_valid, b_valid}), 32'b01);
    chk("tie A rdata kept", 32'(a_rdata), 32'h5A3C);
    tick();

    // timeout
    a_ready = 1; a_cmd = 2'b01; a_addr = 25'h55;
    tick(); a_ready = 0;
    n = 0;
    while (!mc_ready && n < 10) begin tick(); n++; end
    chk("to issued", 32'(mc_ready), 1);
    k = 0;
    while (!a_err && k < 30) begin tick(); k++; end
    chk("to latency", 32'(k), TO + 2);
    mc_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("to late ignored", 32'({a_valid, a_err, a_busy}), 0);
    end
    mc_valid = 0;

    // reset while waiting
    a_ready = 1; a_cmd = 2'b10; a_addr = 25'h1ABCD; a_wdata = 16'hBEEF;
    tick(); a_ready = 0;
    n = 0;
    while (!mc_ready && n < 10) begin tick(); n++; end
    tick(); chk("rw in wait", 32'(mc_addr), 32'h1ABCD);
    rst = 0;
    tick(); rst = 1; mc_valid = 1;
    chk("rw outs", 32'({a_busy, a_valid, a_err, mc_ready, mc_cmd}), 0);
    chk("rw mc_addr", 32'(mc_addr), 0);
    chk("rw rdata", 32'(a_rdata), 0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("rw silent", 32'({a_valid, a_err, mc_ready}), 0);
    end
    mc_valid = 0;

    // both ports keep requesting: grants must alternate
    mc_valid = 1; na = 0; nb = 0; ni = 0;
    for (int c = 0; c < 400 && ni < 8; c++) begin
      if (!a_busy && !a_ready && na < 4) begin
        a_ready = 1; a_cmd = 2'b10; a_addr = {1'b0, 24'(na)}; na++;
      end else a_ready = 0;
      if (!b_busy && !b_ready && nb < 4) begin
        b_ready = 1; b_cmd = 2'b01; b_addr = {1'b1, 24'(nb)}; nb++;
      end else b_ready = 0;
      tick();
      if (mc_ready) begin order[ni] = int'(mc_addr[24]); ni++; end
    end
    a_ready = 0; b_ready = 0; mc_valid = 0;
    chk("rr issues", 32'(ni), 8);
    for (int i = 0; i < 8; i++) chk("rr order", 32'(order[i]), 32'(i % 2));
    for (int i = 0; i < 6; i++) tick();

    // random traffic, including spurious mc_valid and occasional reset
    for (int c = 0; c < 3000; c++) begin
      k = $urandom_range(0, 7);
      a_cmd = (k == 0) ? 2'b00 : (k == 1) ? 2'b11 : (k < 5) ? 2'b01 : 2'b10;
      a_ready = ($urandom_range(0, 2) == 0);
      a_addr = 25'($urandom); a_wdata = 16'($urandom);
      k = $urandom_range(0, 7);
      b_cmd = (k == 0) ? 2'b00 : (k == 1) ? 2'b11 : (k < 5) ? 2'b01 : 2'b10;
      b_ready = ($urandom_range(0, 2) == 0);
      b_addr = 25'($urandom); b_wdata = 16'($urandom);
      mc_valid = ($urandom_range(0, 3) == 0);
      mc_rdata = 16'($urandom);
      rst = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst = 1; a_ready = 0; b_ready = 0; mc_valid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023: max cycles WAIT holds for mc_valid before aborting the transaction.
REQ-002 clk  input  1  system clock, 50 MHz, rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 a_cmd  input  2  requester A one-hot command: 2'b10 WRITE, 2'b01 READ.
REQ-005 a_addr  input  25  requester A address.
REQ-006 a_wdata  input  16  requester A write data.
REQ-007 a_ready  input  1  requester A strobe: a_cmd, a_addr and a_wdata are valid this cycle.
REQ-008 a_busy  output  1  A request pending or in service.
REQ-009 a_valid  output  1  one-cycle pulse: A transaction completed OK.
REQ-010 a_err  output  1  one-cycle pulse: A request rejected or timed out.
REQ-011 a_rdata  output  16  A read data; held until the next A read completes.
REQ-012 b_cmd, b_addr, b_wdata, b_ready, b_busy, b_valid, b_err, b_rdata: requester B ports, widths and meanings identical to A.
REQ-013 mc_cmd  output  2  command to memory_controller.
REQ-014 mc_addr  output  25  address to memory_controller.
REQ-015 mc_wdata  output  16  write data to memory_controller.
REQ-016 mc_ready  output  1  one-cycle issue strobe to memory_controller.
REQ-017 mc_valid  input  1  memory_controller completion flag.
REQ-018 mc_rdata  input  16  memory_controller read data, valid while mc_valid is high.

Function
REQ-019 On x_ready with x_busy low and a legal x_cmd (10 or 01), cmd/addr/wdata shall be latched into a per-port holding register and x_busy shall rise the next cycle.
REQ-020 x_ready with an illegal x_cmd (00 or 11) shall not be latched; x_err shall pulse the next cycle.
REQ-021 x_ready while x_busy is high shall be ignored (no latch, no err).
REQ-022 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-023 IDLE: if any port is pending, grant it and go to ISSUE; if both are pending, grant the port other than last_grant.
REQ-024 ISSUE: mc_ready=1 for exactly one cycle with the granted port's latched cmd/addr/wdata; next state WAIT.
REQ-025 WAIT: mc_cmd/mc_addr/mc_wdata held stable, mc_ready=0; a 10-bit counter increments each cycle.
REQ-026 WAIT exit: mc_valid sampled high -> DONE, capturing mc_rdata into x_rdata if cmd=READ.
REQ-027 WAIT timeout: counter == TIMEOUT without mc_valid -> DONE flagged as error.
REQ-028 DONE: pulse x_valid (or x_err on timeout) for the granted port, clear its pending bit, set last_grant to it, go to IDLE.
REQ-029 Outside ISSUE/WAIT: mc_cmd=2'b00, mc_addr=0, mc_wdata=0, mc_ready=0.
REQ-030 Latency: from x_ready sampled with the FSM in IDLE, mc_ready is high in the cycle after the next edge (2 edges); x_valid is high 2 edges after the mc_valid sample.
REQ-031 A new request to the port in service is accepted only after its x_busy falls, which happens the cycle after the DONE pulse.
REQ-032 Simultaneous a_ready and b_ready shall both be latched; service order follows REQ-023.
REQ-033 mc_valid outside WAIT shall be ignored.

Reset
REQ-034 rst low at a clock edge: FSM=IDLE, pending bits cleared, counter=0, last_grant=B (A wins the first tie), all x_busy/x_valid/x_err=0, x_rdata=0, mc_* outputs per REQ-029.
REQ-035 Reset mid-transaction shall abandon the transaction silently; no valid/err pulse, and any later mc_valid is ignored per REQ-033.

Verification
REQ-036 A WRITE a_cmd=10, addr=25'h0FFFF, wdata=16'hAAAA; mc_valid 5 cycles after mc_ready -> mc_* match, a_valid pulses once, b_* idle.
REQ-037 a_ready and b_ready in the same cycle (A READ 25'h10, B WRITE 25'h20) right after reset -> A is issued first, then B; each valid pulses once; a_rdata = mc_rdata from A's completion.
REQ-038 Back-to-back requests from both ports x4 -> grants alternate A,B,A,B; no starvation.
REQ-039 b_cmd=11 -> b_err pulse the next cycle, no mc_ready, b_busy stays 0.
REQ-040 TIMEOUT=8 and mc_valid never asserted -> a_err pulses 8 WAIT cycles after issue; a late mc_valid is ignored.
REQ-041 rst low during WAIT -> all outputs at reset values the next cycle; no a_valid or a_err.
